// File: rtl/codec_config_sequencer.sv
// Boot-time SSM2603 register loader: walks a fixed 12-entry write table through i2c_controller.
// Optional macro CODEC_CFG_RETRY_EN adds per-register retries on NACK or timeout.
module codec_config_sequencer #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         GAP_CYCLES     = 256,
  parameter int         TIMEOUT_CYCLES = 8192
`ifdef CODEC_CFG_RETRY_EN
  , parameter int       MAX_RETRY      = 3
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reinit,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        cfg_ok,
  output logic        cfg_err,
  output logic [3:0]  fail_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_CLR, S_WAIT_DONE, S_CHECK, S_GAP, S_DONE, S_FAIL
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_INDEX   = 4'd11;

  // Table entry as {reg_addr[6:0], reg_val[8:0]}
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h010};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h012};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h00A};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      4'd11:   table_entry = {7'd6,  9'h000};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic        timeout_q, timeout_d;
  logic [23:0] data_q, data_d;
  logic [3:0]  fail_index_q, fail_index_d;
`ifdef CODEC_CFG_RETRY_EN
  logic [1:0]  retries_q, retries_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      index_q      <= 4'd0;
      timer_q      <= 16'd0;
      timeout_q    <= 1'b0;
      data_q       <= 24'h0;
      fail_index_q <= 4'd0;
`ifdef CODEC_CFG_RETRY_EN
      retries_q    <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      data_q       <= data_d;
      fail_index_q <= fail_index_d;
`ifdef CODEC_CFG_RETRY_EN
      retries_q    <= retries_d;
`endif
    end
  end

  // One timer serves both the done timeout and the inter-write gap; it saturates
  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    timer_d      = timer_q;
    timeout_d    = timeout_q;
    data_d       = data_q;
    fail_index_d = fail_index_q;
`ifdef CODEC_CFG_RETRY_EN
    retries_d    = retries_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        index_d = 4'd0;
`ifdef CODEC_CFG_RETRY_EN
        retries_d = 2'd0;
`endif
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        timer_d   = 16'd0;
        timeout_d = 1'b0;
        state_d   = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        timer_d = timer_inc;
        if (!i2c_done) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_inc;
        if (i2c_done) begin
          state_d = S_CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        timer_d = 16'd0;
        if (i2c_ack && !timeout_q) begin
          if (index_q == LAST_INDEX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
            retries_d = 2'd0;
`endif
            state_d = S_GAP;
          end
        end else begin
`ifdef CODEC_CFG_RETRY_EN
          if (retries_q < 2'(MAX_RETRY)) begin
            retries_d = retries_q + 2'd1;
            state_d   = S_GAP;
          end else begin
            fail_index_d = index_q;
            state_d      = S_FAIL;
          end
`else
          fail_index_d = index_q;
          state_d      = S_FAIL;
`endif
        end
      end
      S_GAP: begin
        timer_d = timer_inc;
        if (timer_q == GAP_LAST) state_d = S_LOAD;
      end
      S_DONE, S_FAIL: begin
        if (reinit) begin
          state_d      = S_LOAD;
          index_d      = 4'd0;
          fail_index_d = 4'd0;
`ifdef CODEC_CFG_RETRY_EN
          retries_d    = 2'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Word is latched on entry to LOAD so it is already stable a cycle before start
    if (state_d == S_LOAD) data_d = {DEV_ADDR, table_entry(index_d)};
  end

  assign i2c_start  = (state_q == S_START);
  assign i2c_data   = data_q;
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign cfg_ok     = (state_q == S_DONE);
  assign cfg_err    = (state_q == S_FAIL);
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Self-checking bench for codec_config_sequencer with a randomized i2c_controller model.
// Expectations follow the CODEC_CFG_RETRY_EN setting of the build.
module tb_codec_config_sequencer;

  localparam int GAP     = 16;
  localparam int TIMEOUT = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reinit = 1'b0;
  logic        i2c_done = 1'b1;
  logic        i2c_ack = 1'b0;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        busy, cfg_ok, cfg_err;
  logic [3:0]  fail_index;

  codec_config_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .reinit(reinit),
    .i2c_start(i2c_start), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .busy(busy), .cfg_ok(cfg_ok), .cfg_err(cfg_err), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int reg_tab [12] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9, 6};
  int val_tab [12] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h00A, 'h000, 'h001, 'h000};

  logic [23:0] sent_q [$];
  logic [23:0] exp_q [$];
  bit          exp_ok;
  int          exp_fail_idx;

  logic [23:0] nack_word = 24'hFFFFFF;
  int          nack_left = 0;
  bit          stuck_low = 1'b0;

  int          m_phase = 0;
  int          m_cnt = 0;
  bit          m_ack_val = 1'b0;
  int          pulse_err = 0;
  int          stable_err = 0;
  logic        prev_start = 1'b0;
  logic [23:0] prev_data = 24'h0;

  function automatic logic [23:0] word_of(input int idx);
    logic [6:0] r;
    logic [8:0] v;
    r = 7'(reg_tab[idx]);
    v = 9'(val_tab[idx]);
    return {8'h34, r, v};
  endfunction

  // Reference: list of words the sequencer should emit and its final outcome
  task automatic build_expected(input logic [23:0] nw, input int nack_times, input bit stuck);
    int  limit, remaining, attempts;
    bit  fail;
    exp_q.delete();
    exp_ok = 1'b1;
    exp_fail_idx = 0;
`ifdef CODEC_CFG_RETRY_EN
    limit = 4;
`else
    limit = 1;
`endif
    remaining = nack_times;
    for (int idx = 0; idx < 12; idx++) begin
      attempts = 0;
      fail = 1'b1;
      while (fail && attempts < limit) begin
        exp_q.push_back(word_of(idx));
        attempts++;
        fail = stuck || (word_of(idx) == nw && remaining != 0);
        if (fail && !stuck && remaining > 0) remaining--;
      end
      if (fail) begin
        exp_ok = 1'b0;
        exp_fail_idx = idx;
        return;
      end
    end
  endtask

  // Controller model: drops done after a start, raises it later with the chosen ack
  always @(negedge clk) begin
    if (i2c_start) begin
      sent_q.push_back(i2c_data);
      if (prev_start) pulse_err++;
      if (i2c_data !== prev_data) stable_err++;
      m_ack_val = !(i2c_data == nack_word && nack_left != 0);
      if (!m_ack_val && nack_left > 0) nack_left--;
      m_cnt = $urandom_range(0, 2);
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_cnt == 0) begin
        i2c_done = 1'b0;
        i2c_ack = 1'b0;
        m_cnt = $urandom_range(4, 30);
        m_phase = 2;
      end else m_cnt--;
    end else if (m_phase == 2) begin
      if (m_cnt == 0) begin
        if (!stuck_low) begin
          i2c_done = 1'b1;
          i2c_ack = m_ack_val;
        end
        m_phase = 0;
      end else m_cnt--;
    end
    prev_start = i2c_start;
    prev_data = i2c_data;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    reinit = 1'b0;
    repeat (3) @(negedge clk);
    sent_q.delete();
    pulse_err = 0;
    stable_err = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_finish(input int budget, output int cycles, output bit expired);
    cycles = 0;
    while (!(cfg_ok || cfg_err) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    expired = !(cfg_ok || cfg_err);
  endtask

  task automatic test_reset();
    nack_word = 24'hFFFFFF; nack_left = 0; stuck_low = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++; if ({i2c_start, busy, cfg_ok, cfg_err} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 0000", {i2c_start, busy, cfg_ok, cfg_err}); end
    tests++; if (i2c_data !== 24'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 000000", i2c_data); end
    tests++; if (fail_index !== 4'd0) begin fails++; $display("[TB] FAIL reset_fail_index: got %0d expected 0", fail_index); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (i2c_data !== 24'h341E00 || i2c_start !== 1'b0) begin fails++; $display("[TB] FAIL load_word: got %h start %b expected 341e00 start 0", i2c_data, i2c_start); end
    @(negedge clk);
    tests++; if (i2c_start !== 1'b1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL first_start: got start %b busy %b expected 1 1", i2c_start, busy); end
  endtask

  task automatic test_all_ack();
    int  cyc;
    bit  exp;
    nack_word = 24'hFFFFFF; nack_left = 0; stuck_low = 1'b0;
    build_expected(24'hFFFFFF, 0, 1'b0);
    do_reset();
    wait_finish(20000, cyc, exp);
    tests++; if (exp) begin fails++; $display("[TB] FAIL all_ack_timeout: no completion within %0d cycles", cyc); end
    tests++; if (sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL all_ack_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      tests++; if (sent_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL all_ack_word%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    tests++; if (sent_q.size() != 12 || sent_q[0] !== 24'h341E00 || sent_q[1] !== 24'h340C10 || sent_q[11] !== 24'h340C00) begin
      fails++; $display("[TB] FAIL all_ack_endpoints: got %0d words, first %h", sent_q.size(), sent_q.size() > 0 ? sent_q[0] : 24'h0);
    end
    tests++; if ({cfg_ok, cfg_err, busy} !== 3'b100) begin fails++; $display("[TB] FAIL all_ack_status: got ok/err/busy %b expected 100", {cfg_ok, cfg_err, busy}); end
    tests++; if (pulse_err != 0 || stable_err != 0) begin fails++; $display("[TB] FAIL start_protocol: got pulse_err %0d stable_err %0d expected 0 0", pulse_err, stable_err); end
  endtask

  task automatic test_reinit();
    int  cyc;
    bit  exp;
    tests++; if (cfg_ok !== 1'b1) begin fails++; $display("[TB] FAIL reinit_precondition: got cfg_ok %b expected 1", cfg_ok); end
    build_expected(24'hFFFFFF, 0, 1'b0);
    sent_q.delete();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    tests++; if ({cfg_ok, busy} !== 2'b01) begin fails++; $display("[TB] FAIL reinit_restart: got ok/busy %b expected 01", {cfg_ok, busy}); end
    for (int k = 0; k < 2000 && sent_q.size() < 3; k++) @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    wait_finish(20000, cyc, exp);
    tests++; if (exp) begin fails++; $display("[TB] FAIL reinit_timeout: no completion within %0d cycles", cyc); end
    tests++; if (sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL reinit_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      tests++; if (sent_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL reinit_word%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    tests++; if (cfg_ok !== 1'b1) begin fails++; $display("[TB] FAIL reinit_ok: got %b expected 1", cfg_ok); end
  endtask

  task automatic test_nack_once();
    int  cyc;
    bit  exp;
    nack_word = 24'h340479; nack_left = 1; stuck_low = 1'b0;
    build_expected(24'h340479, 1, 1'b0);
    do_reset();
    wait_finish(20000, cyc, exp);
    tests++; if (exp) begin fails++; $display("[TB] FAIL nack_once_timeout: no completion within %0d cycles", cyc); end
    tests++; if (sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL nack_once_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      tests++; if (sent_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL nack_once_word%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    tests++; if ({cfg_ok, cfg_err} !== {exp_ok, !exp_ok}) begin fails++; $display("[TB] FAIL nack_once_status: got ok/err %b expected %b", {cfg_ok, cfg_err}, {exp_ok, !exp_ok}); end
    tests++; if (!exp_ok && fail_index !== 4'(exp_fail_idx)) begin fails++; $display("[TB] FAIL nack_once_index: got %0d expected %0d", fail_index, exp_fail_idx); end
  endtask

  task automatic test_nack_always();
    int  cyc;
    bit  exp;
    nack_word = 24'h340479; nack_left = -1; stuck_low = 1'b0;
    build_expected(24'h340479, -1, 1'b0);
    do_reset();
    wait_finish(20000, cyc, exp);
    tests++; if (exp) begin fails++; $display("[TB] FAIL nack_always_timeout: no completion within %0d cycles", cyc); end
    tests++; if (sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL nack_always_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
    tests++; if ({cfg_ok, cfg_err, busy} !== 3'b010) begin fails++; $display("[TB] FAIL nack_always_status: got ok/err/busy %b expected 010", {cfg_ok, cfg_err, busy}); end
    tests++; if (fail_index !== 4'(exp_fail_idx)) begin fails++; $display("[TB] FAIL nack_always_index: got %0d expected %0d", fail_index, exp_fail_idx); end
    nack_left = 0;
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    tests++; if ({cfg_err, fail_index} !== 5'b0_0000) begin fails++; $display("[TB] FAIL fail_reinit_clear: got err %b index %0d expected 0 0", cfg_err, fail_index); end
    wait_finish(20000, cyc, exp);
    tests++; if (exp || cfg_ok !== 1'b1) begin fails++; $display("[TB] FAIL fail_reinit_ok: got cfg_ok %b expected 1", cfg_ok); end
  endtask

  task automatic test_stuck_low();
    int  cyc;
    bit  exp;
    nack_word = 24'hFFFFFF; nack_left = 0; stuck_low = 1'b1;
    build_expected(24'hFFFFFF, 0, 1'b1);
    do_reset();
    wait_finish(20000, cyc, exp);
    tests++; if (exp) begin fails++; $display("[TB] FAIL stuck_timeout: no completion within %0d cycles", cyc); end
    tests++; if ({cfg_ok, cfg_err} !== 2'b01 || fail_index !== 4'd0) begin fails++; $display("[TB] FAIL stuck_status: got ok/err %b index %0d expected 01 0", {cfg_ok, cfg_err}, fail_index); end
    tests++; if (sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL stuck_attempts: got %0d expected %0d", sent_q.size(), exp_q.size()); end
    tests++; if (cyc < exp_q.size() * TIMEOUT || cyc > exp_q.size() * (TIMEOUT + GAP + 8) + 8) begin
      fails++; $display("[TB] FAIL stuck_duration: got %0d cycles expected about %0d", cyc, exp_q.size() * TIMEOUT);
    end
    stuck_low = 1'b0;
  endtask

  task automatic test_async_reset();
    int  cyc;
    bit  exp;
    nack_word = 24'hFFFFFF; nack_left = 0; stuck_low = 1'b0;
    build_expected(24'hFFFFFF, 0, 1'b0);
    do_reset();
    for (int k = 0; k < 5000 && sent_q.size() < 7; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b1 || sent_q.size() != 7) begin fails++; $display("[TB] FAIL areset_precondition: got busy %b writes %0d expected 1 7", busy, sent_q.size()); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if ({i2c_start, busy, cfg_ok, cfg_err} !== 4'b0000 || i2c_data !== 24'h0 || fail_index !== 4'd0) begin
      fails++; $display("[TB] FAIL areset_outputs: got flags %b data %h index %0d expected 0000 000000 0", {i2c_start, busy, cfg_ok, cfg_err}, i2c_data, fail_index);
    end
    repeat (2) @(negedge clk);
    sent_q.delete();
    reset_n = 1'b1;
    for (int k = 0; k < 10 && sent_q.size() < 1; k++) @(negedge clk);
    tests++; if (sent_q.size() < 1 || sent_q[0] !== 24'h341E00) begin fails++; $display("[TB] FAIL areset_restart: got %0d words, first %h expected 341e00", sent_q.size(), sent_q.size() > 0 ? sent_q[0] : 24'h0); end
    wait_finish(20000, cyc, exp);
    tests++; if (exp || cfg_ok !== 1'b1 || sent_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL areset_complete: got ok %b words %0d expected 1 %0d", cfg_ok, sent_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_all_ack();
    test_reinit();
    test_nack_once();
    test_nack_always();
    test_stuck_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
# codec_config_sequencer

- Boot-time configuration sequencer for the SSM2603 audio codec.
- Walks a fixed table of codec register writes and hands each 24-bit word to `i2c_controller` with a one-cycle `start` pulse, then waits for `done` and checks `ack`.
- Retries on NACK or timeout, and reports overall completion or failure to the audio top level.

## Interface
Parameters:
- DEV_ADDR, 8'h34 — codec write address byte (7-bit address 0x1A, R/W=0).
- GAP_CYCLES, 256 — idle clk cycles between the end of one write and the next `start`.
- TIMEOUT_CYCLES, 8192 — max clk cycles to wait for `done` before treating the write as failed.
- MAX_RETRY, 3 — retries per register after the first attempt (used only with retry enabled).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- reinit  in  1  one-cycle pulse; restarts the whole sequence from entry 0 when in DONE or FAIL; ignored otherwise.
- i2c_start  out  1  one-cycle start pulse to `i2c_controller`.
- i2c_data  out  24  {DEV_ADDR, reg_addr[6:0], reg_val[8:0]}; held stable from LOAD until the next LOAD.
- i2c_done  in  1  `done` from `i2c_controller` (level, stays high after completion).
- i2c_ack  in  1  `ack` from `i2c_controller`; valid only while `i2c_done`=1.
- busy  out  1  high in every state except IDLE, DONE and FAIL.
- cfg_ok  out  1  high in DONE.
- cfg_err  out  1  high in FAIL.
- fail_index  out  4  table index of the failing entry; valid in FAIL.

## Operation
Fixed 12-entry table, as (reg, val) with index 0–11:
- 0: R15 = 0x000 (reset)
- 1: R6 = 0x010
- 2: R0 = 0x017
- 3: R1 = 0x017
- 4: R2 = 0x079
- 5: R3 = 0x079
- 6: R4 = 0x012
- 7: R5 = 0x000
- 8: R7 = 0x00A
- 9: R8 = 0x000
- 10: R9 = 0x001
- 11: R6 = 0x000

States and transitions:
- IDLE: entered on reset. Goes to LOAD the first cycle after `reset_n` rises; index=0, retries=0.
- LOAD: register `i2c_data` from table[index] → START.
- START: `i2c_start`=1 for exactly this cycle; clear the timer → WAIT_CLR.
- WAIT_CLR: wait for `i2c_done`=0. This is needed because `done` is still high from the previous write. The timer runs here; on timeout → CHECK as a failure.
- WAIT_DONE: wait for `i2c_done`=1 → CHECK. The timer keeps running; on timeout → CHECK as a failure.
- CHECK: decide the outcome of the write.
  - Success (`i2c_ack`=1, no timeout), last entry (index==11) → DONE.
  - Success, not last → index+1, retries=0, then GAP.
  - Failure → handled by the retry rule under Configuration.
- GAP: count GAP_CYCLES, then → LOAD.
- DONE / FAIL: hold. `reinit` → LOAD with index=0, retries=0, and `cfg_ok`, `cfg_err` and `fail_index` cleared.

Arithmetic and widths:
- index is 4-bit and never exceeds 11.
- Timer is 16-bit and saturates; timeout fires when timer == TIMEOUT_CYCLES-1.
- retries is 2-bit and compared with MAX_RETRY.

## Timing
- Reset values: `i2c_start`=0, `i2c_data`=24'h0, `busy`=0, `cfg_ok`=0, `cfg_err`=0, `fail_index`=0.
- Reset value of state: IDLE.
- Asynchronous reset mid-transaction aborts immediately and `i2c_start` drops. The sequence restarts from entry 0 after release, and `i2c_controller` is re-armed by the next `start`.
- `i2c_data` changes only in LOAD, one cycle before `i2c_start`, so it is stable when the controller samples it.
- The first `i2c_start` is issued on the 3rd rising edge after `reset_n` deasserts (IDLE→LOAD→START).
- Start-to-start spacing is at least the transaction time (about 30×128 clk) + GAP_CYCLES + 3.
- `reinit` arriving in the same cycle the sequence enters DONE or FAIL is ignored.
- `i2c_ack` is sampled only in CHECK.

## Configuration
Macro: CODEC_CFG_RETRY_EN.
- Defined: in CHECK, a failure with retries < MAX_RETRY → retries+1, then GAP, then the same index is rewritten. A failure with retries == MAX_RETRY → FAIL, with `fail_index`=index.
- Undefined: any failure → FAIL immediately, with `fail_index`=index. The MAX_RETRY parameter and the retry counter are absent.

## Test plan
- ACK model always acks; release reset → 12 `start` pulses.
  - `i2c_data` sequence begins 24'h341E00 (R15), 24'h340C10 (R6), and ends 24'h340C00 (R6).
  - `cfg_ok`=1, `busy`=0 afterwards.
- NACK on entry 4 once, with CODEC_CFG_RETRY_EN → entry 4 (24'h340479) is sent twice, then the sequence completes and `cfg_ok`=1.
- NACK on entry 4 always.
  - With the macro: 4 attempts, then `cfg_err`=1, `fail_index`=4.
  - Without it: 1 attempt, then `cfg_err`=1, `fail_index`=4.
- `i2c_done` stuck low → after TIMEOUT_CYCLES, treated as a failure; the retry/FAIL path is taken with `fail_index`=0.
- Async reset asserted during WAIT_DONE of entry 6 → all outputs return to reset values at once; after release, the next `i2c_data` is 24'h341E00.
- In DONE, pulse `reinit` → the full 12-write sequence repeats. A `reinit` pulse while `busy`=1 has no effect.
